soml_addr_gen: RTL and testbench

Parametrised three-level address sequencer for the SOML decoder datapath. It walks a nested (Si, rowH, colS) index space one tuple per cycle, with colS varying fastest. It issues one pass per `start`, or runs back-to-back passes in continuous mode. Stall, valid, last and done signalling let it feed the S-column/H-row operand memories and the Si accumulator stage without external glue.

---
 rtl/soml_addr_gen.sv | 95 +++++++++
 tb/tb_soml_addr_gen.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soml_addr_gen.sv
// Three-level (Si, rowH, colS) address sequencer for the SOML decoder datapath.
// Optional completed-pass counter enabled by defining SOML_AG_PASSCNT_EN.
module soml_addr_gen #(
  parameter int COL_N = 2,
  parameter int ROW_N = 4,
  parameter int SI_N  = 16,
  localparam int COL_W = (COL_N > 1) ? $clog2(COL_N) : 1,
  localparam int ROW_W = (ROW_N > 1) ? $clog2(ROW_N) : 1,
  localparam int SI_W  = (SI_N  > 1) ? $clog2(SI_N)  : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             stall,
  output logic             valid,
  output logic [COL_W-1:0] addr_colS,
  output logic [ROW_W-1:0] addr_rowH,
  output logic [SI_W-1:0]  addr_Si,
  output logic             last,
  output logic             done,
  output logic [15:0]      pass_cnt
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COL_N - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROW_N - 1);
  localparam logic [SI_W-1:0]  SI_MAX  = SI_W'(SI_N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state;
  logic   col_at_max;
  logic   row_at_max;
  logic   si_at_max;
  logic   accept;

  // A modulus of 1 makes the maximum 0, so that level is permanently at max.
  assign col_at_max = (addr_colS == COL_MAX);
  assign row_at_max = (addr_rowH == ROW_MAX);
  assign si_at_max  = (addr_Si   == SI_MAX);

  assign valid  = (state == RUN);
  assign last   = valid & col_at_max & row_at_max & si_at_max;
  assign accept = valid & ~stall;

  // start overrides everything, including stall, but never suppresses done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_colS <= '0;
      addr_rowH <= '0;
      addr_Si   <= '0;
      done      <= 1'b0;
    end else begin
      done <= accept & last;
      if (start) begin
        state     <= RUN;
        addr_colS <= '0;
        addr_rowH <= '0;
        addr_Si   <= '0;
      end else if (accept) begin
        if (last) begin
          addr_colS <= '0;
          addr_rowH <= '0;
          addr_Si   <= '0;
          state     <= cont ? RUN : IDLE;
        end else if (!col_at_max) begin
          addr_colS <= addr_colS + 1'b1;
        end else begin
          addr_colS <= '0;
          if (!row_at_max) begin
            addr_rowH <= addr_rowH + 1'b1;
          end else begin
            addr_rowH <= '0;
            addr_Si   <= addr_Si + 1'b1;
          end
        end
      end
    end
  end

`ifdef SOML_AG_PASSCNT_EN
  // Counts done pulses; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_cnt <= '0;
    end else if (done) begin
      pass_cnt <= pass_cnt + 16'd1;
    end
  end
`else
  assign pass_cnt = '0;
`endif

endmodule

// File: tb/tb_soml_addr_gen.sv
// Self-checking bench for soml_addr_gen: default geometry plus a 3x1x5 instance,
// compared each cycle against a linear-index reference model.
module tb_soml_addr_gen;

  logic clk = 1'b0;
  logic rst;
  logic start = 1'b0;
  logic cont = 1'b0;
  logic stall = 1'b0;

  logic        valid1, last1, done1;
  logic [0:0]  col1;
  logic [1:0]  row1;
  logic [3:0]  si1;
  logic [15:0] pc1;

  logic        valid2, last2, done2;
  logic [1:0]  col2;
  logic [0:0]  row2;
  logic [2:0]  si2;
  logic [15:0] pc2;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  soml_addr_gen dut1 (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .stall(stall),
    .valid(valid1), .addr_colS(col1), .addr_rowH(row1), .addr_Si(si1),
    .last(last1), .done(done1), .pass_cnt(pc1)
  );

  soml_addr_gen #(.COL_N(3), .ROW_N(1), .SI_N(5)) dut2 (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .stall(stall),
    .valid(valid2), .addr_colS(col2), .addr_rowH(row2), .addr_Si(si2),
    .last(last2), .done(done2), .pass_cnt(pc2)
  );

  // Model tracks a pass as a flat tuple index t; coordinates are derived by div/mod.
  typedef struct {
    bit active;
    int t;
    bit done;
    int pass;
  } mdl_t;

  typedef struct {
    bit s, c, st;
    bit v;
    int col, row, si;
    bit l, d;
  } vec_t;

  mdl_t m1, m2;
  mdl_t zeroModel;

  function automatic mdl_t stepModel(mdl_t m, bit s, bit c, bit st, int total);
    mdl_t n;
    bit acc;
    bit isLast;
    n = m;
    acc = m.active && !st;
    isLast = m.active && (m.t == total - 1);
    n.done = acc && isLast;
    if (m.done) n.pass = (m.pass + 1) % 65536;
    if (s) begin
      n.active = 1'b1;
      n.t = 0;
    end else if (acc) begin
      if (isLast) begin
        n.t = 0;
        n.active = c;
      end else begin
        n.t = m.t + 1;
      end
    end
    return n;
  endfunction

  function automatic int expPass(mdl_t m);
`ifdef SOML_AG_PASSCNT_EN
    return m.pass;
`else
    return 0 * m.pass;
`endif
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic checkOutput();
    check("d1.valid", int'(valid1), int'(m1.active));
    check("d1.colS",  int'(col1), m1.t % 2);
    check("d1.rowH",  int'(row1), (m1.t / 2) % 4);
    check("d1.Si",    int'(si1), m1.t / 8);
    check("d1.last",  int'(last1), int'(m1.active && m1.t == 127));
    check("d1.done",  int'(done1), int'(m1.done));
    check("d1.pass",  int'(pc1), expPass(m1));
    check("d2.valid", int'(valid2), int'(m2.active));
    check("d2.colS",  int'(col2), m2.t % 3);
    check("d2.rowH",  int'(row2), 0);
    check("d2.Si",    int'(si2), m2.t / 3);
    check("d2.last",  int'(last2), int'(m2.active && m2.t == 14));
    check("d2.done",  int'(done2), int'(m2.done));
    check("d2.pass",  int'(pc2), expPass(m2));
  endtask

  task automatic applyStimulus(input bit s, input bit c, input bit st);
    start = s;
    cont  = c;
    stall = st;
    @(posedge clk);
    if (!rst) begin
      m1 = zeroModel;
      m2 = zeroModel;
    end else begin
      m1 = stepModel(m1, start, cont, stall, 128);
      m2 = stepModel(m2, start, cont, stall, 15);
    end
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    start = 1'b0;
    cont  = 1'b0;
    stall = 1'b0;
    rst   = 1'b0;
    #1;
    m1 = zeroModel;
    m2 = zeroModel;
    checkOutput();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic waitTuple(input int c, input int r, input int s);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (valid1 && int'(col1) == c && int'(row1) == r && int'(si1) == s) ok = 1'b1;
      else applyStimulus(1'b0, cont, 1'b0);
    end
    check("waitTuple reached", int'(ok), 1);
  endtask

  initial begin
    vec_t vecs[12];
    int nValid, nValid2, doneAt, doneAt2, stallsLeft, nDone;
    int doneCyc[2];
    bit st, expectNext;

    zeroModel = '{active: 1'b0, t: 0, done: 1'b0, pass: 0};
    m1 = zeroModel;
    m2 = zeroModel;

    // Short hand-computed prologue for the default geometry.
    vecs[0]  = '{s:0, c:0, st:0, v:0, col:0, row:0, si:0, l:0, d:0};
    vecs[1]  = '{s:1, c:0, st:0, v:1, col:0, row:0, si:0, l:0, d:0};
    vecs[2]  = '{s:0, c:0, st:0, v:1, col:1, row:0, si:0, l:0, d:0};
    vecs[3]  = '{s:0, c:0, st:1, v:1, col:1, row:0, si:0, l:0, d:0};
    vecs[4]  = '{s:0, c:0, st:1, v:1, col:1, row:0, si:0, l:0, d:0};
    vecs[5]  = '{s:0, c:0, st:0, v:1, col:0, row:1, si:0, l:0, d:0};
    vecs[6]  = '{s:1, c:0, st:0, v:1, col:0, row:0, si:0, l:0, d:0};
    vecs[7]  = '{s:0, c:0, st:0, v:1, col:1, row:0, si:0, l:0, d:0};
    vecs[8]  = '{s:1, c:0, st:1, v:1, col:0, row:0, si:0, l:0, d:0};
    vecs[9]  = '{s:0, c:0, st:0, v:1, col:1, row:0, si:0, l:0, d:0};
    vecs[10] = '{s:0, c:0, st:0, v:1, col:0, row:1, si:0, l:0, d:0};
    vecs[11] = '{s:0, c:0, st:0, v:1, col:1, row:1, si:0, l:0, d:0};

    doReset();
    check("reset valid", int'(valid1), 0);
    check("reset done", int'(done1), 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].s, vecs[i].c, vecs[i].st);
      check($sformatf("vec%0d.valid", i), int'(valid1), int'(vecs[i].v));
      check($sformatf("vec%0d.colS", i), int'(col1), vecs[i].col);
      check($sformatf("vec%0d.rowH", i), int'(row1), vecs[i].row);
      check($sformatf("vec%0d.Si", i), int'(si1), vecs[i].si);
      check($sformatf("vec%0d.last", i), int'(last1), int'(vecs[i].l));
      check($sformatf("vec%0d.done", i), int'(done1), int'(vecs[i].d));
    end

    // Plain single pass on both geometries.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    nValid = 0; nValid2 = 0; doneAt = -1; doneAt2 = -1;
    for (int c = 0; c < 140; c++) begin
      if (valid1) nValid++;
      if (valid2) nValid2++;
      if (done1 && doneAt < 0) doneAt = c;
      if (done2 && doneAt2 < 0) doneAt2 = c;
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    check("pass valid count", nValid, 128);
    check("pass done cycle", doneAt, 128);
    check("small valid count", nValid2, 15);
    check("small done cycle", doneAt2, 15);
    check("idle after pass", int'(valid1), 0);

    // Three-cycle stall at (1,2,5).
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    nValid = 0; stallsLeft = 3; expectNext = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (done1) break;
      if (valid1) nValid++;
      st = valid1 && col1 == 1'd1 && row1 == 2'd2 && si1 == 4'd5 && stallsLeft > 0;
      if (st) stallsLeft--;
      else if (valid1 && col1 == 1'd1 && row1 == 2'd2 && si1 == 4'd5) expectNext = 1'b1;
      applyStimulus(1'b0, 1'b0, st);
      if (expectNext) begin
        check("after stall tuple", {29'd0, col1, row1}, 3);
        check("after stall Si", int'(si1), 5);
        expectNext = 1'b0;
      end
    end
    check("stalled pass length", nValid, 131);

    // Continuous mode for two passes.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0);
    nDone = 0; doneCyc[0] = -1; doneCyc[1] = -1;
    for (int c = 0; c < 300; c++) begin
      if (done1) begin
        if (nDone < 2) doneCyc[nDone] = c;
        nDone++;
      end
      if (c == 128) check("cont no bubble", int'(valid1), 1);
      applyStimulus(1'b0, nDone == 0, 1'b0);
    end
    check("cont done count", nDone, 2);
    check("cont done spacing", doneCyc[1] - doneCyc[0], 128);
`ifdef SOML_AG_PASSCNT_EN
    check("cont pass_cnt", int'(pc1), 2);
`else
    check("cont pass_cnt", int'(pc1), 0);
`endif

    // Restart mid-pass at (0,2,7).
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitTuple(0, 2, 7);
    applyStimulus(1'b1, 1'b0, 1'b0);
    check("restart valid", int'(valid1), 1);
    check("restart tuple", {27'd0, col1, row1, si1}, 0);
    check("restart no done", int'(done1), 0);
    nValid = 0;
    for (int c = 0; c < 140; c++) begin
      if (valid1) nValid++;
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    check("restart pass length", nValid, 128);

    // Asynchronous reset mid-pass at (1,1,3).
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitTuple(1, 1, 3);
    #2;
    rst = 1'b0;
    #1;
    m1 = zeroModel;
    m2 = zeroModel;
    check("async rst valid", int'(valid1), 0);
    check("async rst tuple", {27'd0, col1, row1, si1}, 0);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 1'b0);
    check("idle after rst", int'(valid1), 0);

    // Randomised traffic against the model.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 99) < 20);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
